pipelined_barrel_shifter: RTL and testbench
===========================================

# pipelined_barrel_shifter

Parametrised, pipelined barrel shifter for the execute stage.
- Widths: any power-of-two width.
- Operations: logical left, logical right, arithmetic right and rotate right.
- Registers are inserted between log-shift levels at a configurable interval.
- Handshake: valid/ready on both sides with a sideband tag, so the block can run as a multi-cycle functional unit beside the ALU.

## Interface
- WIDTH, 64: data width; power of two, 8..128.
- SHW, $clog2(WIDTH): shift-amount width; derived, not overridden.
- REG_EVERY, 1: mux levels per register stage, 1..SHW. Latency L = ceil(SHW/REG_EVERY) cycles.
- TAG_W, 5: width of the opaque tag carried alongside the data (destination register).

Ports (clock and reset first):
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block accepts the input this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  SHW  shift amount; only the low SHW bits are meaningful.
- in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Shift network: level k (k = 0..SHW-1) shifts by 2^k when amt[k]=1, else passes through. The levels are grouped into L register stages of REG_EVERY levels each; the last group may be shorter.
- Each stage register holds: data, remaining amt bits, op, tag, valid.
- Fill per operation:
  - SLL: zero fill from the LSB end.
  - SRL: zero fill from the MSB end.
  - SRA: fills with the original operand MSB. The sign is captured at input and carried through the stages.
  - ROTR: bits shifted out at the LSB end re-enter at the MSB end.
- Amount 0 returns in_data unchanged for every op.
- Amount WIDTH-1 is the maximum. No amount wraps beyond SHW bits.
- Global stall: advance = !out_valid || out_ready. While advance=0, every stage register holds its value. in_ready = advance.
- Accept: a transfer occurs when in_valid && in_ready. Otherwise a bubble (valid=0) enters stage 0 on advance.
- Results leave strictly in acceptance order. No reordering and no bubble collapsing.
- flush=1: every stage valid bit (including out_valid) clears at the next edge. Data and tag registers may keep stale values. in_ready is forced to 0 during flush, so no input is accepted that cycle.
- Simultaneous flush and accept: flush wins and the input is dropped; the producer sees in_ready=0.

## Timing
- Reset (rst_n=0 at an edge) clears:
  - all stage valids, so out_valid=0;
  - out_data=0 and out_tag=0.
- After reset, in_ready=1 in the first cycle after deassertion.
- Reset mid-operation discards all in-flight ops; no partial result is ever emitted.
- Latency: an op accepted at edge t shows out_valid=1 with its result after edge t+L-1, i.e. visible in cycle t+L-1 following acceptance. With REG_EVERY=SHW, L=1: the result is registered once and appears in the cycle after acceptance.
- Throughput: one op per cycle while out_ready=1.
- Backpressure: out_valid && !out_ready stalls all stages and drops in_ready in the same cycle (combinational from out_valid/out_ready/flush). out_data and out_tag stay stable until the transfer.
- No combinational path from in_* to out_*.

## Test plan
Parameters unless noted: WIDTH=32, REG_EVERY=1, L=5, out_ready=1.
- Basic ops:
  - SLL 0x00000001 by 31 -> 0x80000000.
  - SRL 0x80000000 by 4 -> 0x08000000.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - ROTR 0x12345678 by 8 -> 0x78123456.
  - Each result appears exactly 5 cycles after acceptance.
- Edge amounts, each through all 4 ops:
  - amount 0 on 0xDEADBEEF -> 0xDEADBEEF.
  - SRA 0x7FFFFFFF by 31 -> 0x00000000.
  - ROTR 0x00000001 by 31 -> 0x00000002.
- Streaming and backpressure:
  - Input: back-to-back 20 random ops with tags 0..19.
  - Stall: out_ready low for 3 cycles mid-stream. Required: in_ready low in exactly those cycles, out_data held stable, all 20 results in tag order with none lost or duplicated, results match the reference model.
- Flush: 3 ops in flight plus flush together with a new in_valid -> no out_valid for the next 5 cycles, and the flushed-cycle input is not accepted.
- Reset: rst_n low for 1 cycle with 4 ops in flight -> out_valid=0, out_data=0, out_tag=0 next cycle, and no stale result emerges later.
- Parameter sweep: WIDTH in {8, 64, 128}, REG_EVERY in {1, 2, SHW}. Random ops versus the model; latency equals ceil(SHW/REG_EVERY) in every configuration.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: valid/ready barrel shifter for the execute stage.
// The log-shift levels (level k shifts by 2^k) are grouped REG_EVERY at a
// time, and each group ends in a register stage, so the latency is
// ceil(SHW/REG_EVERY) cycles. The whole pipe stalls together when the output
// is held, and flush kills every in-flight operation.
module pipelined_barrel_shifter #(
  parameter int WIDTH     = 64,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 5,
  localparam int SHW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int L = (SHW + REG_EVERY - 1) / REG_EVERY;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // One mux level. The SRA fill uses the operand sign captured at the input,
  // because after earlier levels the current MSB is already fill material.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       op,
                                                   input logic             sign,
                                                   input int               sh);
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] res;
    fill = sign ? ~({WIDTH{1'b1}} >> sh) : '0;
    case (op)
      OP_SLL:  res = d << sh;
      OP_SRL:  res = d >> sh;
      OP_SRA:  res = (d >> sh) | fill;
      default: res = (d >> sh) | (d << (WIDTH - sh));
    endcase
    return res;
  endfunction

  // Stage s register contents; index L-1 is the output stage.
  logic [L-1:0][WIDTH-1:0] data_d,  data_q;
  logic [L-1:0][SHW-1:0]   amt_d,   amt_q;
  logic [L-1:0][1:0]       op_d,    op_q;
  logic [L-1:0][TAG_W-1:0] tag_d,   tag_q;
  logic [L-1:0]            sign_d,  sign_q;
  logic [L-1:0]            valid_d, valid_q;

  logic advance;

  // Whole pipe moves only when the output slot is empty or being consumed.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !flush;

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int LO = s * REG_EVERY;
    localparam int HI = (LO + REG_EVERY < SHW) ? LO + REG_EVERY : SHW;

    logic [WIDTH-1:0] src_data;
    logic [SHW-1:0]   src_amt;
    logic [1:0]       src_op;
    logic [TAG_W-1:0] src_tag;
    logic             src_sign;
    logic             src_valid;
    logic [WIDTH-1:0] work;

    if (s == 0) begin : g_src_in
      assign src_data  = in_data;
      assign src_amt   = in_amt;
      assign src_op    = in_op;
      assign src_tag   = in_tag;
      assign src_sign  = in_data[WIDTH-1];
      assign src_valid = in_valid;
    end else begin : g_src_prev
      assign src_data  = data_q[s-1];
      assign src_amt   = amt_q[s-1];
      assign src_op    = op_q[s-1];
      assign src_tag   = tag_q[s-1];
      assign src_sign  = sign_q[s-1];
      assign src_valid = valid_q[s-1];
    end

    // Apply this group's mux levels to the operand entering the stage.
    always_comb begin
      work = src_data;
      for (int k = LO; k < HI; k++) begin
        if (src_amt[k]) begin
          work = shift_level(work, src_op, src_sign, 1 << k);
        end
      end
    end

    assign data_d[s]  = work;
    assign amt_d[s]   = src_amt;
    assign op_d[s]    = src_op;
    assign tag_d[s]   = src_tag;
    assign sign_d[s]  = src_sign;
    assign valid_d[s] = src_valid;
  end

  // Stage registers: all hold on stall; flush clears every valid bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      sign_q  <= '0;
      valid_q <= '0;
    end else begin
      if (advance) begin
        data_q  <= data_d;
        amt_q   <= amt_d;
        op_q    <= op_d;
        tag_q   <= tag_d;
        sign_q  <= sign_d;
        valid_q <= valid_d;
      end
      if (flush) begin
        valid_q <= '0;
      end
    end
  end

  assign out_valid = valid_q[L-1];
  assign out_data  = data_q[L-1];
  assign out_tag   = tag_q[L-1];

  // Control fields of the output stage have no further consumer.
  logic unused_out_ctrl;
  assign unused_out_ctrl = ^{amt_q[L-1], op_q[L-1], sign_q[L-1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: a WIDTH=32, REG_EVERY=1 instance for the
// functional scenarios plus nine instances covering the width/interval sweep.
module tb_pipelined_barrel_shifter;

  localparam int LAT  = 5;
  localparam int NCFG = 9;
  localparam int NSW  = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_op;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(32), .REG_EVERY(1), .TAG_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag));

  function automatic int cfg_w(input int c);
    if (c < 3) return 8;
    else if (c < 6) return 64;
    else return 128;
  endfunction

  function automatic int cfg_shw(input int c);
    return $clog2(cfg_w(c));
  endfunction

  function automatic int cfg_re(input int c);
    if (c % 3 == 0) return 1;
    else if (c % 3 == 1) return 2;
    else return cfg_shw(c);
  endfunction

  function automatic int cfg_lat(input int c);
    return (cfg_shw(c) + cfg_re(c) - 1) / cfg_re(c);
  endfunction

  // Reference: the whole shift done at once on a w-bit operand.
  function automatic logic [127:0] ref_shift(input logic [127:0] d, input int amt,
                                             input logic [1:0] op, input int w);
    logic [127:0]        mask;
    logic [127:0]        r;
    logic [127:0]        dm;
    logic signed [127:0] sx;
    mask = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
    dm = d & mask;
    case (op)
      2'd0: r = dm << amt;
      2'd1: r = dm >> amt;
      2'd2: begin
        sx = dm << (128 - w);
        sx = sx >>> (128 - w);
        sx = sx >>> amt;
        r = sx;
      end
      default: r = (dm >> amt) | (dm << (w - amt));
    endcase
    return r & mask;
  endfunction

  logic [127:0] sw_data;
  logic [6:0]   sw_amt;
  logic [1:0]   sw_op;
  logic [4:0]   sw_tag;
  logic         sw_valid;
  logic [127:0] sw_out_data  [NCFG];
  logic [4:0]   sw_out_tag   [NCFG];
  logic         sw_out_valid [NCFG];
  logic         sw_in_ready  [NCFG];

  for (genvar c = 0; c < NCFG; c++) begin : g_sweep
    localparam int CW = cfg_w(c);
    localparam int CS = cfg_shw(c);
    localparam int CR = cfg_re(c);
    logic [CW-1:0] od;
    pipelined_barrel_shifter #(.WIDTH(CW), .REG_EVERY(CR), .TAG_W(5)) u_sw (
      .clk(clk), .rst_n(rst_n), .flush(1'b0),
      .in_valid(sw_valid), .in_ready(sw_in_ready[c]), .in_data(sw_data[CW-1:0]),
      .in_amt(sw_amt[CS-1:0]), .in_op(sw_op), .in_tag(sw_tag),
      .out_valid(sw_out_valid[c]), .out_ready(1'b1),
      .out_data(od), .out_tag(sw_out_tag[c]));
    assign sw_out_data[c] = 128'(od);
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++;
    if (out_tag !== 5'h0) begin errors++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic_ops();
    logic [31:0] td [4];
    logic [4:0]  ta [4];
    logic [1:0]  to [4];
    logic [31:0] te [4];
    int          seen;
    int          nvalid;
    logic [31:0] got_d;
    logic [4:0]  got_t;
    td = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h12345678};
    ta = '{5'd31, 5'd4, 5'd4, 5'd8};
    to = '{2'd0, 2'd1, 2'd2, 2'd3};
    te = '{32'h80000000, 32'h08000000, 32'hF8000000, 32'h78123456};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = td[i]; in_amt = ta[i]; in_op = to[i]; in_tag = 5'(i + 3);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready op=%0d: got %b want 1", i, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      seen = -1; nvalid = 0; got_d = '0; got_t = '0;
      for (int c = 1; c <= LAT + 2; c++) begin
        @(negedge clk);
        if (out_valid === 1'b1) begin
          nvalid++;
          if (seen < 0) begin seen = c; got_d = out_data; got_t = out_tag; end
        end
      end
      checks++;
      if (seen != LAT) begin errors++; $display("FAIL basic_latency op=%0d: got %0d want %0d", i, seen, LAT); end
      checks++;
      if (nvalid != 1) begin errors++; $display("FAIL basic_valid_count op=%0d: got %0d want 1", i, nvalid); end
      checks++;
      if (got_d !== te[i]) begin errors++; $display("FAIL basic_data op=%0d: got %h want %h", i, got_d, te[i]); end
      checks++;
      if (got_t !== 5'(i + 3)) begin errors++; $display("FAIL basic_tag op=%0d: got %0d want %0d", i, got_t, i + 3); end
    end
  endtask

  task automatic test_edge_amounts();
    logic [31:0] ed [4];
    logic [4:0]  ea [4];
    logic [31:0] ee [16];
    logic [31:0] exp_q [$];
    logic [4:0]  tq [$];
    logic [31:0] e_d;
    logic [4:0]  e_t;
    int          sent;
    int          got;
    ed = '{32'hDEADBEEF, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    ea = '{5'd0, 5'd31, 5'd31, 5'd31};
    ee = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
           32'h80000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFE,
           32'h80000000, 32'h00000000, 32'h00000000, 32'h00000002,
           32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h00000001};
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
      @(posedge clk); #1;
      if (sent < 16) begin
        in_valid = 1'b1; in_data = ed[sent / 4]; in_amt = ea[sent / 4];
        in_op = 2'(sent % 4); in_tag = 5'(sent);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid === 1'b1) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL edge_unexpected: got tag %0d want none", out_tag);
        end else begin
          e_d = exp_q.pop_front(); e_t = tq.pop_front();
          if (out_data !== e_d) begin errors++; $display("FAIL edge_data tag=%0d: got %h want %h", e_t, out_data, e_d); end
          checks++;
          if (out_tag !== e_t) begin errors++; $display("FAIL edge_tag: got %0d want %0d", out_tag, e_t); end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ee[sent]); tq.push_back(5'(sent)); sent++;
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    checks++;
    if (got != 16) begin errors++; $display("FAIL edge_count: got %0d want 16", got); end
  endtask

  task automatic test_stream_backpressure();
    logic [31:0] sd [20];
    logic [4:0]  sa [20];
    logic [1:0]  so [20];
    logic [31:0] exp_q [$];
    logic [4:0]  tq [$];
    logic [31:0] e_d;
    logic [4:0]  e_t;
    logic [31:0] held_d;
    logic [4:0]  held_t;
    logic        exp_rdy;
    int          sent;
    int          got;
    int          cyc;
    for (int i = 0; i < 20; i++) begin
      sd[i] = $urandom; sa[i] = 5'($urandom_range(0, 31)); so[i] = 2'($urandom_range(0, 3));
    end
    sent = 0; got = 0; cyc = 0; held_d = '0; held_t = '0;
    while (got < 20 && cyc < 120) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 8 && cyc <= 10);
      if (sent < 20) begin
        in_valid = 1'b1; in_data = sd[sent]; in_amt = sa[sent]; in_op = so[sent]; in_tag = 5'(sent);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (sent < 20) begin
        exp_rdy = !(cyc >= 8 && cyc <= 10);
        checks++;
        if (in_ready !== exp_rdy) begin errors++; $display("FAIL stream_in_ready cyc=%0d: got %b want %b", cyc, in_ready, exp_rdy); end
      end
      if (cyc == 8) begin held_d = out_data; held_t = out_tag; end
      if (cyc == 9 || cyc == 10) begin
        checks++;
        if (out_data !== held_d || out_tag !== held_t)
          begin errors++; $display("FAIL stall_hold cyc=%0d: got %h/%0d want %h/%0d", cyc, out_data, out_tag, held_d, held_t); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_unexpected: got tag %0d want none", out_tag);
        end else begin
          e_d = exp_q.pop_front(); e_t = tq.pop_front();
          if (out_data !== e_d) begin errors++; $display("FAIL stream_data tag=%0d: got %h want %h", e_t, out_data, e_d); end
          checks++;
          if (out_tag !== e_t) begin errors++; $display("FAIL stream_tag: got %0d want %0d", out_tag, e_t); end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(32'(ref_shift(128'(sd[sent]), int'(sa[sent]), so[sent], 32)));
        tq.push_back(5'(sent));
        sent++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 20) begin errors++; $display("FAIL stream_count: got %0d want 20", got); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_extra c=%0d: got %b want 0", c, out_valid); end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 32'hA5A5_0000 | 32'(i); in_amt = 5'(i + 1); in_op = 2'(i); in_tag = 5'(20 + i);
    end
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hCAFEF00D; in_amt = 5'd3; in_op = 2'd3; in_tag = 5'd30;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_out c=%0d: got %b want 0", c, out_valid); end
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 32'hFFFFFFFF; in_amt = 5'd0; in_op = 2'(i); in_tag = 5'(i + 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL midreset_data: got %h want 0", out_data); end
    checks++;
    if (out_tag !== 5'h0) begin errors++; $display("FAIL midreset_tag: got %0d want 0", out_tag); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_stale c=%0d: got %b want 0", c, out_valid); end
    end
  endtask

  task automatic test_param_sweep();
    logic [127:0] sd [NSW];
    logic [6:0]   sa [NSW];
    logic [1:0]   so [NSW];
    logic         sv [NSW];
    logic [127:0] e_d;
    logic         ev;
    int           idx;
    for (int i = 0; i < NSW; i++) begin
      sd[i] = {$urandom, $urandom, $urandom, $urandom};
      sa[i] = 7'($urandom_range(0, 127));
      so[i] = 2'($urandom_range(0, 3));
      sv[i] = ($urandom_range(0, 3) != 0);
    end
    sa[0] = 7'd127; sv[0] = 1'b1; so[0] = 2'd2; sd[0][127] = 1'b1; sd[0][63] = 1'b1; sd[0][7] = 1'b1;
    for (int cyc = 0; cyc < NSW + 8; cyc++) begin
      @(posedge clk); #1;
      if (cyc < NSW) begin
        sw_valid = sv[cyc]; sw_data = sd[cyc]; sw_amt = sa[cyc]; sw_op = so[cyc]; sw_tag = 5'(cyc);
      end else begin
        sw_valid = 1'b0;
      end
      @(negedge clk);
      for (int c = 0; c < NCFG; c++) begin
        idx = cyc - cfg_lat(c);
        ev = (idx >= 0 && idx < NSW) ? sv[idx] : 1'b0;
        checks++;
        if (sw_out_valid[c] !== ev)
          begin errors++; $display("FAIL sweep_valid cfg=%0d cyc=%0d: got %b want %b", c, cyc, sw_out_valid[c], ev); end
        if (ev) begin
          e_d = ref_shift(sd[idx], int'(sa[idx]) % cfg_w(c), so[idx], cfg_w(c));
          checks++;
          if (sw_out_data[c] !== e_d)
            begin errors++; $display("FAIL sweep_data cfg=%0d cyc=%0d: got %h want %h", c, cyc, sw_out_data[c], e_d); end
          checks++;
          if (sw_out_tag[c] !== 5'(idx))
            begin errors++; $display("FAIL sweep_tag cfg=%0d cyc=%0d: got %0d want %0d", c, cyc, sw_out_tag[c], idx); end
        end
        checks++;
        if (sw_in_ready[c] !== 1'b1)
          begin errors++; $display("FAIL sweep_in_ready cfg=%0d cyc=%0d: got %b want 1", c, cyc, sw_in_ready[c]); end
      end
    end
    @(posedge clk); #1 sw_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0;
    in_op = '0; in_tag = '0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_data = '0; sw_amt = '0; sw_op = '0; sw_tag = '0;
    test_reset();
    test_basic_ops();
    test_edge_amounts();
    test_stream_backpressure();
    test_flush();
    test_reset_midflight();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
